// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable reference-clock divider.
// Holds the default ratio width, the smallest ratio that actually divides,
// and the two-state run/idle encoding carried by the active register.
package clk_div_pkg;

  localparam int RATIO_W_DEF   = 8;
  localparam int MIN_DIV_RATIO = 2;

  // DIV_RUN doubles as the o_active value, so the encoding must stay 0/1.
  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
// Inputs: i_clk_en, i_div_ratio, i_sync. Outputs: o_div_clk, o_div_pulse, o_active.
// master = ratio/enable source, slave = divider.
interface clk_div_prog_if #(
  parameter int RATIO_W = 8
);

  logic               i_clk_en;
  logic [RATIO_W-1:0] i_div_ratio;
  logic               i_sync;
  logic               o_div_clk;
  logic               o_div_pulse;
  logic               o_active;

  modport master (
    output i_clk_en,
    output i_div_ratio,
    output i_sync,
    input  o_div_clk,
    input  o_div_pulse,
    input  o_active
  );

  modport slave (
    input  i_clk_en,
    input  i_div_ratio,
    input  i_sync,
    output o_div_clk,
    output o_div_pulse,
    output o_active
  );

endinterface

// File: rtl/clk_bypass_mux.sv
// Selects the divided clock or the raw reference clock.
// Ports: i_sel_div (1 = divided), i_div_clk, i_ref_clk, o_clk.
// Kept as its own cell so backend can replace it with a glitch-safe clock mux.
module clk_bypass_mux (
  input  logic i_sel_div,
  input  logic i_div_clk,
  input  logic i_ref_clk,
  output logic o_clk
);

  assign o_clk = i_sel_div ? i_div_clk : i_ref_clk;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer divider of i_ref_clk with period strobe and active flag.
// Ports: i_ref_clk, i_rst_n (async, active low), bus (slave: enable/ratio/sync in,
// divided clock/pulse/active out). Outputs are registered except the bypass mux.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int RATIO_W   = RATIO_W_DEF,
  parameter int RST_RATIO = 0
) (
  input  logic          i_ref_clk,
  input  logic          i_rst_n,
  clk_div_prog_if.slave bus
);

  div_state_e         state_q, state_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic [RATIO_W-1:0] shadow_q, shadow_d;
  logic               div_q, div_d;
  logic               pulse_q, pulse_d;

  logic               ratio_ok;
  logic [RATIO_W-1:0] half;
  logic [RATIO_W-1:0] cnt_inc;
  logic               at_boundary;

  // A request is only usable when it actually divides; smaller ratios mean bypass.
  assign ratio_ok    = bus.i_clk_en && (bus.i_div_ratio >= RATIO_W'(MIN_DIV_RATIO));
  // High time comes from the adopted ratio so mid-period requests cannot disturb it.
  assign half        = shadow_q >> 1;
  // cnt never passes shadow-1 while running, so the increment cannot wrap.
  assign cnt_inc     = cnt_q + RATIO_W'(1);
  assign at_boundary = (cnt_q == shadow_q - RATIO_W'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    div_d    = div_q;
    pulse_d  = 1'b0;

    if (state_q == DIV_IDLE) begin
      if (ratio_ok) begin
        state_d  = DIV_RUN;
        shadow_d = bus.i_div_ratio;
        cnt_d    = '0;
        div_d    = 1'b1;
        pulse_d  = 1'b1;
      end
    end else begin
      if (!bus.i_clk_en) begin
        // Immediate abort, mid-period if need be; this edge is not glitch-free.
        state_d = DIV_IDLE;
        cnt_d   = '0;
        div_d   = 1'b0;
      end else if ((bus.i_sync || at_boundary) && ratio_ok) begin
        // New period: adopt the requested ratio (sync forces this early).
        shadow_d = bus.i_div_ratio;
        cnt_d    = '0;
        div_d    = 1'b1;
        pulse_d  = 1'b1;
      end else if (at_boundary) begin
        // Period finished and the request no longer divides.
        state_d = DIV_IDLE;
        cnt_d   = '0;
        div_d   = 1'b0;
      end else begin
        cnt_d = cnt_inc;
        div_d = (cnt_inc < half);
      end
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      shadow_q <= RATIO_W'(RST_RATIO);
      div_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      div_q    <= div_d;
      pulse_q  <= pulse_d;
    end
  end

  assign bus.o_div_pulse = pulse_q;
  assign bus.o_active    = (state_q == DIV_RUN);

  clk_bypass_mux u_bypass_mux (
    .i_sel_div (state_q == DIV_RUN),
    .i_div_clk (div_q),
    .i_ref_clk (i_ref_clk),
    .o_clk     (bus.o_div_clk)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: 8-bit and 12-bit instances on one reference clock.
// Expected per-cycle outputs are queued as stimulus is applied, then popped
// and compared one reference cycle at a time, sampled 1 time unit after posedge.
module tb_clk_div_prog;

  typedef struct {
    logic clk;
    logic pulse;
    logic act;
  } exp_t;

  logic ref_clk;
  logic rst_n;
  int   total;
  int   passed;
  int   cyc;
  exp_t sb[$];

  clk_div_prog_if #(.RATIO_W(8))  bus   ();
  clk_div_prog_if #(.RATIO_W(12)) bus_w ();

  clk_div_prog #(.RATIO_W(8), .RST_RATIO(0)) dut (
    .i_ref_clk (ref_clk),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  clk_div_prog #(.RATIO_W(12), .RST_RATIO(0)) dut_w (
    .i_ref_clk (ref_clk),
    .i_rst_n   (rst_n),
    .bus       (bus_w)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  // Expected output for position k of an N-cycle period: high for the first N/2.
  task automatic push_period(input int n, input int k0, input int k1);
    exp_t e;
    for (int k = k0; k <= k1; k++) begin
      e.clk   = (k < n / 2);
      e.pulse = (k == 0);
      e.act   = 1'b1;
      sb.push_back(e);
    end
  endtask

  // Bypass sampled just after a rising edge: o_div_clk follows ref_clk (high).
  task automatic push_idle(input int count);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      e.clk   = 1'b1;
      e.pulse = 1'b0;
      e.act   = 1'b0;
      sb.push_back(e);
    end
  endtask

  // Advance one reference cycle and pop the matching expectation.
  task automatic next_cycle(input bit wide, output logic [2:0] got, output logic [2:0] want);
    exp_t e;
    @(posedge ref_clk);
    #1;
    cyc++;
    e = sb.pop_front();
    if (wide) got = {bus_w.o_div_clk, bus_w.o_div_pulse, bus_w.o_active};
    else      got = {bus.o_div_clk, bus.o_div_pulse, bus.o_active};
    want = {e.clk, e.pulse, e.act};
  endtask

  task automatic test_reset();
    @(posedge ref_clk);
    #1;
    total++;
    if ({bus.o_div_clk, bus.o_div_pulse, bus.o_active} !== 3'b100)
      $display("FAIL reset_hi: clk/pulse/active got %b expected 100",
               {bus.o_div_clk, bus.o_div_pulse, bus.o_active});
    else passed++;
    @(negedge ref_clk);
    #1;
    total++;
    if ({bus.o_div_clk, bus.o_div_pulse, bus.o_active} !== 3'b000)
      $display("FAIL reset_lo: clk/pulse/active got %b expected 000",
               {bus.o_div_clk, bus.o_div_pulse, bus.o_active});
    else passed++;
    total++;
    if ({bus_w.o_div_pulse, bus_w.o_active} !== 2'b00)
      $display("FAIL reset_wide: pulse/active got %b expected 00",
               {bus_w.o_div_pulse, bus_w.o_active});
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_ratio(input int n);
    logic [2:0] got, want;
    bus.i_clk_en    = 1'b1;
    bus.i_div_ratio = 8'(n);
    for (int p = 0; p < 3; p++) push_period(n, 0, n - 1);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL ratio%0d cyc %0d: clk/pulse/active got %b expected %b", n, cyc, got, want);
      else passed++;
    end
    bus.i_clk_en = 1'b0;
    push_idle(2);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL ratio%0d_stop cyc %0d: clk/pulse/active got %b expected %b", n, cyc, got, want);
      else passed++;
    end
  endtask

  task automatic test_ratio_change();
    logic [2:0] got, want;
    bus.i_clk_en    = 1'b1;
    bus.i_div_ratio = 8'd4;
    push_period(4, 0, 1);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL chg_pre cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
    // Request 6 while cnt=1: the current period must still end at 4.
    bus.i_div_ratio = 8'd6;
    push_period(4, 2, 3);
    push_period(6, 0, 5);
    push_period(6, 0, 5);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL chg_post cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
    bus.i_clk_en = 1'b0;
    push_idle(1);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL chg_stop cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
  endtask

  task automatic test_low_ratio();
    logic [2:0] got, want;
    for (int r = 0; r < 2; r++) begin
      bus.i_clk_en    = 1'b1;
      bus.i_div_ratio = 8'(r);
      push_idle(3);
      while (sb.size() > 0) begin
        next_cycle(1'b0, got, want);
        total++;
        if (got !== want)
          $display("FAIL low_ratio%0d cyc %0d: clk/pulse/active got %b expected %b", r, cyc, got, want);
        else passed++;
      end
      @(negedge ref_clk);
      #1;
      total++;
      if ({bus.o_div_clk, bus.o_active} !== 2'b00)
        $display("FAIL low_ratio%0d_track: clk/active got %b expected 00", r,
                 {bus.o_div_clk, bus.o_active});
      else passed++;
    end
    bus.i_clk_en = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [2:0] got, want;
    bus.i_clk_en    = 1'b1;
    bus.i_div_ratio = 8'd8;
    push_period(8, 0, 5);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL endrop_run cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
    bus.i_clk_en = 1'b0;
    push_idle(3);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL endrop_idle cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
  endtask

  task automatic test_sync();
    logic [2:0] got, want;
    bus.i_clk_en    = 1'b1;
    bus.i_div_ratio = 8'd8;
    push_period(8, 0, 3);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL sync_pre cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
    bus.i_sync = 1'b1;
    push_period(8, 0, 0);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL sync_restart cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
    bus.i_sync = 1'b0;
    push_period(8, 1, 7);
    push_period(8, 0, 7);
    bus.i_clk_en = 1'b1;
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL sync_post cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
    bus.i_clk_en = 1'b0;
    push_idle(1);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL sync_stop cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] got, want;
    bus.i_clk_en    = 1'b1;
    bus.i_div_ratio = 8'd6;
    push_period(6, 0, 2);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL rstmid_pre cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
    // Asynchronous assertion between edges, with cnt=2.
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.o_div_clk, bus.o_div_pulse, bus.o_active} !== 3'b100)
      $display("FAIL rstmid_async: clk/pulse/active got %b expected 100",
               {bus.o_div_clk, bus.o_div_pulse, bus.o_active});
    else passed++;
    push_idle(3);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL rstmid_held cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
    rst_n = 1'b1;
    push_period(6, 0, 5);
    push_period(6, 0, 5);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL rstmid_post cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
    bus.i_clk_en = 1'b0;
    push_idle(1);
    while (sb.size() > 0) begin
      next_cycle(1'b0, got, want);
      total++;
      if (got !== want)
        $display("FAIL rstmid_stop cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
  endtask

  task automatic test_wide_max();
    logic [2:0] got, want;
    bus_w.i_clk_en    = 1'b1;
    bus_w.i_div_ratio = 12'd4095;
    push_period(4095, 0, 4094);
    push_period(4095, 0, 0);
    while (sb.size() > 0) begin
      next_cycle(1'b1, got, want);
      total++;
      if (got !== want)
        $display("FAIL wide4095 cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
    bus_w.i_clk_en = 1'b0;
    push_idle(1);
    while (sb.size() > 0) begin
      next_cycle(1'b1, got, want);
      total++;
      if (got !== want)
        $display("FAIL wide_stop cyc %0d: clk/pulse/active got %b expected %b", cyc, got, want);
      else passed++;
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    bus.i_clk_en      = 1'b0;
    bus.i_div_ratio   = '0;
    bus.i_sync        = 1'b0;
    bus_w.i_clk_en    = 1'b0;
    bus_w.i_div_ratio = '0;
    bus_w.i_sync      = 1'b0;

    test_reset();
    test_ratio(4);
    test_ratio(5);
    test_ratio(2);
    test_ratio(3);
    test_ratio_change();
    test_low_ratio();
    test_enable_drop();
    test_sync();
    test_reset_mid();
    test_wide_max();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Parametrised, programmable integer clock divider for the reference-clock tree. It produces a divided clock, an aligned one-cycle strobe, and an active flag.
- Ratio changes are glitch-free: a new ratio is adopted only at a period boundary.
- Supports phase re-alignment via a sync input.
- Falls back to reference-clock bypass when disabled or when the ratio is below 2.
- Successor of the fixed 8-bit divider, for UART/SPI baud and peripheral clock generation.

Parameters:
- RATIO_W, 8, width of the division ratio and of the internal counter.
- RST_RATIO, 0, shadow ratio loaded at reset (0 means start in bypass).

Ports:
- i_ref_clk  in  1  reference clock; all registers on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clk_en  in  1  divider enable; 0 forces bypass.
- i_div_ratio  in  RATIO_W  requested division ratio N.
- i_sync  in  1  phase restart request, sampled on the rising edge.
- o_div_clk  out  1  divided clock; equals i_ref_clk when in bypass.
- o_div_pulse  out  1  one-ref-cycle strobe marking the first cycle of each divided period.
- o_active  out  1  1 while dividing, 0 in bypass.

Behaviour:
- Reset (async, i_rst_n=0):
  - cnt=0, div_q=0, pulse=0, active=0, shadow=RST_RATIO.
  - Outputs: o_div_pulse=0, o_active=0, o_div_clk=i_ref_clk (bypass).
- Duty: for active ratio N, H = N>>1.
  - o_div_clk is high for H cycles and low for N-H cycles; period is exactly N ref cycles.
  - Even N gives 50% duty. Odd N is high floor(N/2), low ceil(N/2).
- Idle to active: at an edge with i_clk_en=1 and i_div_ratio>=2:
  - shadow<=i_div_ratio, cnt<=0, div_q<=1, pulse<=1, active<=1.
  - Latency: the first divided high phase starts 1 cycle after the enabling edge.
- Active, normal edge (cnt != shadow-1): cnt<=cnt+1, div_q<=(cnt+1 < H), pulse<=0.
- Active, boundary edge (cnt == shadow-1):
  - If i_clk_en=1 and i_div_ratio>=2: shadow<=i_div_ratio, cnt<=0, div_q<=1, pulse<=1. H is recomputed from the new shadow.
  - Otherwise go idle: active<=0, cnt<=0, div_q<=0, pulse<=0.
- i_clk_en=0 while active: go idle at the next edge, mid-period, without waiting for a boundary. This abort is intentional and documented as non-glitch-free.
- i_sync=1 while active with i_clk_en=1 and i_div_ratio>=2: behaves as a boundary edge regardless of cnt. It reloads the ratio, sets cnt=0, div_q=1, pulse=1.
- i_sync while idle: no effect beyond the normal idle-to-active rule.
- Simultaneous events, priority: reset > i_clk_en=0 > i_sync > boundary > count.
- Ratio change mid-period: ignored until the boundary. The current period always completes at the old N.
- Arithmetic:
  - cnt is RATIO_W bits and never exceeds shadow-1, so no wrap-around is possible.
  - H is computed from shadow, never from i_div_ratio.
  - Maximum N = 2^RATIO_W - 1.
- Output mux: o_div_clk = active ? div_q : i_ref_clk. This is the only combinational path from i_ref_clk to an output. o_div_pulse and o_active are registered.
- Reset mid-operation: immediate return to the reset state. No partial period is emitted after release.

Decomposition:
- Shared package clk_div_pkg holds:
  - RATIO_W default.
  - constant MIN_DIV_RATIO = 2.
  - a state enum {DIV_IDLE, DIV_RUN}. The active register encodes it.
- Sub-module clk_bypass_mux isolates the active/i_ref_clk select, so backend can swap it for a clock-gating-safe cell.
- Counter and control logic stay in clk_div_prog.

Test Plan:
- Reset then i_clk_en=1, ratio=4 -> o_div_clk pattern 1,1,0,0 repeating; o_div_pulse high every 4th cycle, coinciding with the rising output; o_active=1 one cycle after enable.
- ratio=5 -> high 2, low 3, period 5; ratio=2 -> alternating 1,0; ratio=3 -> 1,0,0.
- While running ratio=4, change to 6 at cnt=1 -> the current period completes at 4, the next period is 6 (high 3, low 3), and no short pulse occurs.
- ratio=1 or ratio=0 with i_clk_en=1 -> o_active=0, o_div_clk tracks i_ref_clk. With ratio=8 running, drop i_clk_en at cnt=5 -> o_active=0 at the next edge and bypass resumes.
- ratio=8 running, i_sync pulse at cnt=3 -> next cycle cnt=0, o_div_pulse=1, o_div_clk=1, then 8-cycle periods from that point.
- i_rst_n asserted at cnt=2 with ratio=6, released 3 cycles later with i_clk_en=1 -> outputs are reset values during reset; the first pulse is one cycle after the first post-release edge; RATIO_W=12 build with ratio=4095 -> high 2047, low 2048.
